// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch with a one-entry skid buffer and IF/ID register.
// Revision    : 1.0
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] instr_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d,
    output logic [5:0]  opcode_d
);

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    localparam logic [31:0] c_reset_pc = RESET_PC & 32'hFFFF_FFFC;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pcplus4;
    logic [31:0] r_instr_d;
    logic [31:0] r_pcplus4_d;
    logic        r_valid_d;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pcplus4;
    logic        w_deliver;
    logic [31:0] w_deliver_instr;
    logic [31:0] w_deliver_pcplus4;
    logic        w_skid_load;

    assign w_redirect = jump | branch_taken;
    assign w_target   = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;
    assign w_pcplus4  = r_pc + 32'd4;

    // A redirect always wins: whatever arrives or is buffered belongs to the wrong path.
    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_deliver         = 1'b0;
        w_deliver_instr   = r_skid_instr;
        w_deliver_pcplus4 = r_skid_pcplus4;
        w_skid_load       = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_redirect) begin
                    w_pc_next = w_target;
                end else if (imem_valid) begin
                    if (!stall) begin
                        w_deliver         = 1'b1;
                        w_deliver_instr   = imem_rdata;
                        w_deliver_pcplus4 = w_pcplus4;
                        w_pc_next         = w_pcplus4;
                    end else begin
                        w_skid_load  = 1'b1;
                        w_state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (w_redirect) begin
                    w_pc_next    = w_target;
                    w_state_next = S_FETCH;
                end else if (!stall) begin
                    w_deliver    = 1'b1;
                    w_pc_next    = w_pcplus4;
                    w_state_next = S_FETCH;
                end
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_pc    <= c_reset_pc;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_instr   <= 32'd0;
            r_skid_pcplus4 <= 32'd0;
        end else if (w_skid_load) begin
            r_skid_instr   <= imem_rdata;
            r_skid_pcplus4 <= w_pcplus4;
        end
    end

    // Flush beats stall beats load; an unfilled slot becomes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_d   <= 32'd0;
            r_pcplus4_d <= 32'd0;
            r_valid_d   <= 1'b0;
        end else if (flush) begin
            r_instr_d   <= 32'd0;
            r_pcplus4_d <= 32'd0;
            r_valid_d   <= 1'b0;
        end else if (!stall) begin
            if (w_deliver) begin
                r_instr_d   <= w_deliver_instr;
                r_pcplus4_d <= w_deliver_pcplus4;
                r_valid_d   <= 1'b1;
            end else begin
                r_instr_d   <= 32'd0;
                r_pcplus4_d <= 32'd0;
                r_valid_d   <= 1'b0;
            end
        end
    end

    assign imem_addr = r_pc;
    assign imem_req  = rst_n & (r_state == S_FETCH);
    assign instr_d   = r_instr_d;
    assign pcplus4_d = r_pcplus4_d;
    assign valid_d   = r_valid_d;
    assign opcode_d  = r_instr_d[31:26];

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed plus randomized self-checking bench for fetch_stage.
// Revision    : 1.0
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk           = 1'b0;
    logic        rst_n         = 1'b0;
    logic [31:0] imem_rdata    = 32'd0;
    logic        imem_valid    = 1'b0;
    logic        stall         = 1'b0;
    logic        flush         = 1'b0;
    logic        branch_taken  = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump          = 1'b0;
    logic [31:0] jump_target   = 32'd0;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] instr_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic [5:0]  opcode_d;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .instr_d(instr_d), .pcplus4_d(pcplus4_d),
        .valid_d(valid_d), .opcode_d(opcode_d)
    );

    // Instruction memory contents as a pure function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        if (a == 32'h4) return 32'h0000_0000;
        return {a[15:0] ^ 16'h5A3C, a[31:16] + 16'h1357};
    endfunction

    // Reference model: which address is being fetched, whether one fetched word
    // is parked waiting for the stall to clear, and what IF/ID must show.
    typedef struct packed {
        logic [31:0] pc;
        bit          parked;
        logic [31:0] parked_instr;
        logic [31:0] instr;
        logic [31:0] pc4;
        bit          valid;
        bit          pc4_known;
    } mstate_t;

    mstate_t m = '0;

    function automatic mstate_t model_reset();
        mstate_t r = '0;
        r.pc        = RESET_PC;
        r.pc4_known = 1'b1;
        return r;
    endfunction

    function automatic mstate_t model_next(input mstate_t s);
        mstate_t     n = s;
        bit          got = 1'b0;
        logic [31:0] got_instr = 32'd0;
        logic [31:0] tgt;
        tgt = jump ? {jump_target[31:2], 2'b00} : {branch_target[31:2], 2'b00};
        if (jump || branch_taken) begin
            n.pc     = tgt;
            n.parked = 1'b0;
        end else if (s.parked) begin
            if (!stall) begin
                got       = 1'b1;
                got_instr = s.parked_instr;
                n.pc      = s.pc + 32'd4;
                n.parked  = 1'b0;
            end
        end else if (imem_valid) begin
            if (stall) begin
                n.parked       = 1'b1;
                n.parked_instr = mem_word(s.pc);
            end else begin
                got       = 1'b1;
                got_instr = mem_word(s.pc);
                n.pc      = s.pc + 32'd4;
            end
        end
        if (flush) begin
            n.instr = 32'd0; n.pc4 = 32'd0; n.valid = 1'b0; n.pc4_known = 1'b1;
        end else if (!stall) begin
            if (got) begin
                n.instr = got_instr; n.pc4 = s.pc + 32'd4; n.valid = 1'b1; n.pc4_known = 1'b1;
            end else begin
                n.instr = 32'd0; n.valid = 1'b0; n.pc4_known = 1'b0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= model_reset();
        else        m <= model_next(m);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model.imem_addr", imem_addr, m.pc);
            check("model.imem_req", {31'd0, imem_req}, {31'd0, rst_n && !m.parked});
            check("model.instr_d", instr_d, m.instr);
            check("model.valid_d", {31'd0, valid_d}, {31'd0, m.valid});
            check("model.opcode_d", {26'd0, opcode_d}, {26'd0, m.instr[31:26]});
            if (m.pc4_known) check("model.pcplus4_d", pcplus4_d, m.pc4);
        end
    end

    task automatic drive(input bit v, input bit st, input bit fl,
                         input bit br, input logic [31:0] bt,
                         input bit jp, input logic [31:0] jt);
        imem_valid    = v;
        stall         = st;
        flush         = fl;
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        imem_rdata    = v ? mem_word(m.pc) : $urandom;
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] ins,
                              input logic [31:0] p4, input bit v);
        check({tag, ".instr_d"}, instr_d, ins);
        check({tag, ".pcplus4_d"}, pcplus4_d, p4);
        check({tag, ".valid_d"}, {31'd0, valid_d}, {31'd0, v});
    endtask

    task automatic reset_pulse(input string tag);
        #3 rst_n = 1'b0;
        #1;
        check_ifid(tag, 32'd0, 32'd0, 1'b0);
        check({tag, ".addr"}, imem_addr, RESET_PC);
        check({tag, ".req"}, {31'd0, imem_req}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check({tag, ".addr_after"}, imem_addr, RESET_PC);
        check({tag, ".req_after"}, {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        check_ifid("reset", 32'd0, 32'd0, 1'b0);
        check("reset.req", {31'd0, imem_req}, 32'd0);
        check("reset.addr", imem_addr, 32'h0);
        rst_n = 1'b1;
        #1;
        check("first.addr", imem_addr, 32'h0);
        check("first.req", {31'd0, imem_req}, 32'd1);

        // Zero-wait fetch of the first two words
        drive(1, 0, 0, 0, 0, 0, 0);
        check_ifid("w0", 32'h2008_0005, 32'h4, 1'b1);
        check("w0.opcode", {26'd0, opcode_d}, 32'h08);
        check("w0.addr", imem_addr, 32'h4);
        drive(1, 0, 0, 0, 0, 0, 0);
        check_ifid("w1", 32'h0, 32'h8, 1'b1);
        check("w1.addr", imem_addr, 32'h8);

        // Three wait states at 0x8
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            check("wait.addr", imem_addr, 32'h8);
            check("wait.valid", {31'd0, valid_d}, 32'd0);
        end
        drive(1, 0, 0, 0, 0, 0, 0);
        check_ifid("w8", 32'h5A34_1357, 32'hC, 1'b1);
        check("w8.addr", imem_addr, 32'hC);
        drive(1, 0, 0, 0, 0, 0, 0);
        check_ifid("wC", 32'h5A30_1357, 32'h10, 1'b1);

        // Response under stall parks in the skid buffer
        drive(1, 1, 0, 0, 0, 0, 0);
        check("hold.req", {31'd0, imem_req}, 32'd0);
        check("hold.addr", imem_addr, 32'h10);
        check_ifid("hold", 32'h5A30_1357, 32'h10, 1'b1);
        drive(0, 1, 0, 0, 0, 0, 0);
        check("hold2.req", {31'd0, imem_req}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check_ifid("unhold", 32'h5A2C_1357, 32'h14, 1'b1);
        check("unhold.addr", imem_addr, 32'h14);

        // Jump beats branch; response that cycle is dropped
        drive(1, 0, 0, 1, 32'h80, 1, 32'h40);
        check("jump.addr", imem_addr, 32'h40);
        check("jump.valid", {31'd0, valid_d}, 32'd0);
        drive(0, 0, 0, 1, 32'h83, 0, 32'h0);
        check("branch.addr", imem_addr, 32'h80);
        drive(1, 0, 0, 0, 0, 0, 0);
        check_ifid("w80", 32'h5ABC_1357, 32'h84, 1'b1);

        // Flush overrides stall
        drive(0, 1, 1, 0, 0, 0, 0);
        check_ifid("flush", 32'd0, 32'd0, 1'b0);
        check("flush.addr", imem_addr, 32'h84);

        // Reset in the middle of a wait
        drive(0, 0, 0, 0, 0, 0, 0);
        reset_pulse("rst_wait");

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 9) == 0, $urandom,
                  $urandom_range(0, 19) == 0, $urandom);
            if ($urandom_range(0, 199) == 0) reset_pulse("rst_rand");
        end

        drive(0, 0, 0, 0, 0, 0, 0);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
